// File: rtl/fifo_wptr_full_ext.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wptr_full_ext
//  Purpose  : Write-domain pointer and status logic for an asynchronous FIFO.
//             Keeps the binary write pointer and a registered Gray copy for
//             the CDC path. Derives full, fill level and almost-full from the
//             synchronised Gray read pointer.
//  Ports    : WCLK, WRSTn (sync, active-low)   - clock / reset
//             WINC                             - write request
//             WQ2_RPTR   [PTR_W]               - Gray read ptr, in WCLK domain
//             WAFULL_LVL [PTR_W]               - almost-full threshold (words)
//             WOVF_CLR                         - clears sticky overflow
//             WADDR      [ADDR_W]              - RAM write address
//             WPTR       [PTR_W]               - registered Gray write ptr
//             WFULL, WAFULL                    - registered full / almost-full
//             WLEVEL     [PTR_W]               - registered fill level
//             WOVF                             - sticky overflow flag
//  Macro    : FIFO_WR_OVF_EN - builds the WOVF register and WOVF_CLR logic;
//             without it WOVF is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wptr_full_ext #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PTR_W  = ADDR_W + 1
) (
    input  logic              WCLK,
    input  logic              WRSTn,
    input  logic              WINC,
    input  logic [PTR_W-1:0]  WQ2_RPTR,
    input  logic [PTR_W-1:0]  WAFULL_LVL,
    input  logic              WOVF_CLR,
    output logic [ADDR_W-1:0] WADDR,
    output logic [PTR_W-1:0]  WPTR,
    output logic              WFULL,
    output logic              WAFULL,
    output logic [PTR_W-1:0]  WLEVEL,
    output logic              WOVF
);

    logic [PTR_W-1:0] wbin_q,   wbin_d;
    logic [PTR_W-1:0] wptr_q,   wptr_d;
    logic [PTR_W-1:0] wlevel_q, wlevel_d;
    logic             wfull_q,  wfull_d;
    logic             wafull_q, wafull_d;

    logic             w_wr_ok;
    logic [PTR_W-1:0] w_rbin;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        w_rbin[PTR_W-1] = WQ2_RPTR[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ WQ2_RPTR[i];
        end
    end

    always_comb begin
        w_wr_ok  = WINC & ~wfull_q;
        wbin_d   = wbin_q + PTR_W'(w_wr_ok);
        wptr_d   = wbin_d ^ (wbin_d >> 1);
        wlevel_d = wbin_d - w_rbin;
        // Full when the next write pointer sits exactly one lap ahead of the
        // read pointer: in Gray code that is the top two bits inverted.
        wfull_d  = (wptr_d == {~WQ2_RPTR[PTR_W-1:PTR_W-2], WQ2_RPTR[PTR_W-3:0]});
        wafull_d = (wlevel_d >= WAFULL_LVL);
    end

    always_ff @(posedge WCLK) begin
        if (!WRSTn) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

    assign WADDR  = wbin_q[ADDR_W-1:0];
    assign WPTR   = wptr_q;
    assign WFULL  = wfull_q;
    assign WAFULL = wafull_q;
    assign WLEVEL = wlevel_q;

`ifdef FIFO_WR_OVF_EN
    logic wovf_q, wovf_d;

    // A rejected write sets the flag; it beats a simultaneous clear.
    always_comb begin
        wovf_d = (WINC & wfull_q) | (wovf_q & ~WOVF_CLR);
    end

    always_ff @(posedge WCLK) begin
        if (!WRSTn) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
        end
    end

    assign WOVF = wovf_q;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = WOVF_CLR;
    assign WOVF = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wptr_full_ext
//  Purpose  : Self-checking bench for fifo_wptr_full_ext (DEPTH = 16). The
//             reference model tracks total words written and read as plain
//             integers and derives every expected output from them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full_ext;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = 5;

`ifdef FIFO_WR_OVF_EN
    localparam bit c_ovf_en = 1'b1;
`else
    localparam bit c_ovf_en = 1'b0;
`endif

    logic              WCLK = 1'b0;
    logic              WRSTn;
    logic              WINC;
    logic [PTR_W-1:0]  WQ2_RPTR;
    logic [PTR_W-1:0]  WAFULL_LVL;
    logic              WOVF_CLR;
    logic [ADDR_W-1:0] WADDR;
    logic [PTR_W-1:0]  WPTR;
    logic              WFULL;
    logic              WAFULL;
    logic [PTR_W-1:0]  WLEVEL;
    logic              WOVF;

    fifo_wptr_full_ext #(.DEPTH(DEPTH)) dut (
        .WCLK       (WCLK),
        .WRSTn      (WRSTn),
        .WINC       (WINC),
        .WQ2_RPTR   (WQ2_RPTR),
        .WAFULL_LVL (WAFULL_LVL),
        .WOVF_CLR   (WOVF_CLR),
        .WADDR      (WADDR),
        .WPTR       (WPTR),
        .WFULL      (WFULL),
        .WAFULL     (WAFULL),
        .WLEVEL     (WLEVEL),
        .WOVF       (WOVF)
    );

    always #5 WCLK = ~WCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: total words written / read since reset.
    int m_wr   = 0;
    int m_rd   = 0;
    int m_lev  = 0;
    int m_lvl  = 0;
    bit m_full = 1'b0;
    bit m_afl  = 1'b0;
    bit m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PTR_W-1:0] gray_of(input int n);
        logic [PTR_W-1:0] b;
        b = PTR_W'(n % 32);
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, check.
    task automatic step(input bit winc, input bit clr, input bit rstn);
        bit acc;
        WINC       = winc;
        WOVF_CLR   = clr;
        WRSTn      = rstn;
        WQ2_RPTR   = gray_of(m_rd);
        WAFULL_LVL = PTR_W'(m_lvl);
        @(posedge WCLK);
        if (!rstn) begin
            m_wr = 0; m_lev = 0; m_full = 0; m_afl = 0; m_ovf = 0;
        end else begin
            acc    = winc && !m_full;
            m_ovf  = c_ovf_en && ((winc && m_full) || (m_ovf && !clr));
            m_wr   = m_wr + int'(acc);
            m_lev  = m_wr - m_rd;
            m_full = (m_lev == DEPTH);
            m_afl  = (m_lev >= m_lvl);
        end
        #1;
        chk("waddr",  32'(WADDR),  32'(m_wr % DEPTH));
        chk("wptr",   32'(WPTR),   32'(gray_of(m_wr)));
        chk("wlevel", 32'(WLEVEL), 32'(m_lev));
        chk("wfull",  32'(WFULL),  32'(m_full));
        chk("wafull", 32'(WAFULL), 32'(m_afl));
        chk("wovf",   32'(WOVF),   32'(m_ovf));
    endtask

    task automatic do_reset();
        m_rd = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    bit saw_full;

    initial begin
        WINC = 0; WOVF_CLR = 0; WRSTn = 0; WQ2_RPTR = '0; WAFULL_LVL = '0;
        m_lvl = 16;
        do_reset();

        // 1. Reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        do_reset();
        chk("rst_waddr", 32'(WADDR), 32'd0);
        chk("rst_wptr",  32'(WPTR),  32'd0);
        step(1'b1, 1'b0, 1'b1);

        // 2. Fill to full with the reader idle
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_waddr_pre", 32'(WADDR), 32'(i));
            step(1'b1, 1'b0, 1'b1);
        end
        chk("full_wptr",   32'(WPTR),   32'b11000);
        chk("full_wlevel", 32'(WLEVEL), 32'd16);
        chk("full_flag",   32'(WFULL),  32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("full_hold_wptr", 32'(WPTR), 32'b11000);

        // 3. Overflow while full: set, hold, clear, set-beats-clear
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // 4. Almost-full threshold at 12
        m_lvl = 12;
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
        chk("afull_at12", 32'(WAFULL), 32'd1);
        m_rd = 1;
        step(1'b0, 1'b0, 1'b1);
        chk("afull_lvl11", 32'(WLEVEL), 32'd11);
        chk("afull_drop",  32'(WAFULL), 32'd0);

        // 5. Wrap-around with the reader trailing by 4 words
        m_lvl = 16;
        do_reset();
        saw_full = 1'b0;
        for (int i = 0; i < 40; i++) begin
            m_rd = (m_wr > 4) ? m_wr - 4 : 0;
            step(1'b1, 1'b0, 1'b1);
            saw_full |= WFULL;
        end
        chk("wrap_nofull", 32'(saw_full), 32'd0);
        chk("wrap_wptr",   32'(WPTR),     32'b01100);

        // 6. Full release coinciding with a write
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1);
        m_rd = 1;
        step(1'b1, 1'b0, 1'b1);
        chk("rel_full", 32'(WFULL), 32'd0);
        chk("rel_wptr", 32'(WPTR),  32'b11000);
        chk("rel_waddr_pre", 32'(WADDR), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("rel_accept_wptr", 32'(WPTR), 32'(gray_of(17)));

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit rst_now;
            if (i % 50 == 0) m_lvl = int'($urandom_range(0, DEPTH));
            rst_now = ($urandom_range(0, 149) == 0);
            if (rst_now) m_rd = 0;
            else if (m_rd < m_wr && $urandom_range(0, 2) == 0) m_rd++;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, !rst_now);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wptr_full_ext.md
# fifo_wptr_full_ext

Write-domain pointer and status logic for the asynchronous FIFO. It is the parametrised successor of the basic write-pointer/full block. It keeps a binary write pointer and a registered Gray pointer for the CDC path. It also computes a registered full flag, a write-side fill level, and a programmable almost-full flag from the 2-FF-synchronised Gray read pointer. Optionally, it records write attempts made while the FIFO is full in a sticky overflow flag. It sits in the write clock domain, between the producer and the dual-port RAM write port, and drives WPTR into the read-domain synchroniser.

## Interface
- DEPTH, 16, FIFO depth in words; power of two, ≥ 4
- ADDR_W, $clog2(DEPTH), RAM address width
- PTR_W, ADDR_W+1, pointer width (extra wrap bit)

- WCLK  in  1  write clock; all logic on rising edge
- WRSTn  in  1  reset: synchronous, active-low
- WINC  in  1  write request; accepted when WINC & ~WFULL
- WQ2_RPTR  in  PTR_W  read pointer, Gray code, already synchronised into WCLK
- WAFULL_LVL  in  PTR_W  almost-full threshold in words (0..DEPTH)
- WOVF_CLR  in  1  clears WOVF; ignored without FIFO_WR_OVF_EN
- WADDR  out  ADDR_W  RAM write address, binary = wbin[ADDR_W-1:0]
- WPTR  out  PTR_W  write pointer, Gray, registered
- WFULL  out  1  FIFO full, registered
- WAFULL  out  1  level ≥ WAFULL_LVL, registered
- WLEVEL  out  PTR_W  words in FIFO as seen by write domain, registered, 0..DEPTH
- WOVF  out  1  sticky overflow flag; constant 0 without FIFO_WR_OVF_EN

## Operation
- Accept: `wr_ok = WINC & ~WFULL`. The next binary pointer is `wbin_nx = wbin + wr_ok`, modulo 2^PTR_W.
- Gray: `wgray_nx = wbin_nx ^ (wbin_nx >> 1)`.
- Register `WPTR <= wgray_nx`. WPTR is a pure register, so it is glitch-free for CDC.
- Read pointer conversion: rbin = Gray-to-binary of WQ2_RPTR, using an XOR prefix from the MSB.
- Level: `level_nx = wbin_nx - rbin`, modulo 2^PTR_W. Register it as `WLEVEL <= level_nx`.
- Full: `WFULL <= (wgray_nx == {~WQ2_RPTR[PTR_W-1:PTR_W-2], WQ2_RPTR[PTR_W-3:0]})`.
- Almost-full: `WAFULL <= (level_nx >= WAFULL_LVL)`, unsigned compare.
- Overflow (macro on):
  - Set WOVF when WINC & WFULL.
  - Clear WOVF when WOVF_CLR.
  - If set and clear occur in the same cycle, set wins.
- Status is pessimistic. A read-pointer advance lowers WFULL, WAFULL and WLEVEL no earlier than the edge after the new WQ2_RPTR value is sampled.
- No state machine. Wrap-around is implicit modular arithmetic on PTR_W bits.

## Timing
- Reset (WRSTn low at a WCLK edge): wbin = 0, WPTR = 0, WADDR = 0, WFULL = 0, WAFULL = 0, WLEVEL = 0, WOVF = 0.
  - Reset takes priority over all inputs, including a write in progress.
  - WAFULL_LVL = 0 makes WAFULL = 1 from the first edge after reset.
- WADDR is valid in the same cycle as the WINC it serves. The RAM writes on the same edge that advances wbin.
- WFULL rises on the edge that accepts the DEPTH-th outstanding word. No write is accepted in the following cycle.
- Simultaneous WINC, WFULL = 1 and a read-pointer advance: the write is rejected (WOVF sets if enabled). WFULL falls on that edge, so a write is accepted the next cycle.
- Write-domain latency: WINC to WPTR/WLEVEL/WFULL/WAFULL is 1 cycle. WQ2_RPTR to status is 1 cycle.
- WLEVEL never exceeds DEPTH. WLEVEL = DEPTH if and only if WFULL = 1.

## Configuration
- FIFO_WR_OVF_EN
  - Defined: the WOVF register and WOVF_CLR logic are compiled in as described above.
  - Undefined: WOVF is tied to 0, WOVF_CLR is unused, and no flop is inferred.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use DEPTH = 16, PTR_W = 5.
1. **Reset mid-write:** pull WRSTn low for 2 cycles during a burst of writes. Required response: every output reads 0 on the next edge, and the next accepted write uses WADDR = 0.
2. **Fill to full:** issue 16 back-to-back writes with WQ2_RPTR = 0. Required response:
   - WADDR runs 0..15.
   - After the 16th accept: WFULL = 1, WLEVEL = 16, WPTR = 5'b11000.
   - A 17th WINC leaves WPTR unchanged.
3. **Overflow (macro on):** hold WINC for 3 cycles while full. Required response:
   - WOVF = 1 from the first rejected cycle and stays set after WINC drops.
   - A one-cycle WOVF_CLR returns WOVF to 0.
   - WOVF_CLR asserted together with a rejected WINC keeps WOVF = 1.
4. **Almost-full:** set WAFULL_LVL = 12 and write 12 words. Required response:
   - WAFULL rises on the 12th accept edge.
   - Setting WQ2_RPTR = 5'b00001 gives WLEVEL = 11 and WAFULL = 0 one edge later.
5. **Wrap-around:** perform 40 writes with the read pointer trailing by 4 words (Gray-coded). Required response:
   - WADDR wraps 15 → 0 twice.
   - WFULL is never asserted.
   - Final WPTR = Gray(8) = 5'b01100.
6. **Full release with simultaneous write:** with the FIFO full, WINC = 1 and WQ2_RPTR advancing 0 → 1 in the same cycle. Required response: the write is rejected that cycle, WFULL = 0 after the edge, and the write is accepted the next cycle with WADDR = 0.
